i2c_codec_target: RTL and testbench

- I2C target (responder) that emulates the codec's write-only control port.
- Decodes the 3-byte write frames sent by the codec configuration master: device address+W, {reg[6:0],d[8]}, d[7:0].
- Stores the 9-bit register values and exposes them for readback.
- Used as an on-chip loopback target to check codec configuration sequences without the physical codec; also usable as a generic control-register sink.

---
 rtl/i2c_codec_target_if.sv | 27 ++
 rtl/i2c_codec_target.sv | 172 +++++++++++++++++
 tb/tb_i2c_codec_target.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_codec_target_if.sv
// Bus bundle for the codec-control I2C target: the pins, the committed-write
// strobe, the readback port and the status outputs.
interface i2c_codec_target_if;
    logic       scl;
    logic       sda_in;
    logic       sda_oe;
    logic       wr_valid;
    logic [6:0] wr_addr;
    logic [8:0] wr_data;
    logic [6:0] rd_addr;
    logic [8:0] rd_data;
    logic       busy;
    logic [7:0] frame_cnt;
    logic       err;

    // The target side (the design)
    modport slave (
        input  scl, sda_in, rd_addr,
        output sda_oe, wr_valid, wr_addr, wr_data, rd_data, busy, frame_cnt, err
    );

    // The bus-master / host side
    modport master (
        output scl, sda_in, rd_addr,
        input  sda_oe, wr_valid, wr_addr, wr_data, rd_data, busy, frame_cnt, err
    );
endinterface

// File: rtl/i2c_codec_target.sv
// I2C write-only target emulating a codec control port.
// Frames: {DEV_ADDR,W}, {reg[6:0],d[8]}, d[7:0]. 9-bit values are stored in a
// small register file with combinational readback.
// Optional input glitch filter: define I2C_TGT_GLITCH_FILTER_EN.
module i2c_codec_target #(
    parameter logic [6:0] DEV_ADDR  = 7'h1A,
    parameter int         NUM_REGS  = 19,
    parameter logic [6:0] RESET_REG = 7'h0F
) (
    input  logic              clk,
    input  logic              reset_n,
    i2c_codec_target_if.slave bus
);
    localparam int         IDX_W     = $clog2(NUM_REGS);
    localparam logic [6:0] REG_LIMIT = 7'(NUM_REGS);

    typedef enum logic [2:0] {
        IDLE, ADDR, ACK_A, REGHI, ACK_H, DATLO, ACK_L, IGNORE
    } state_t;

    // Index 1 = SCL, index 0 = SDA
    logic [1:0] pin;
    logic [1:0] line;
    logic [1:0] line_prev;

    assign pin = {bus.scl, bus.sda_in};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cond
            logic [1:0] sync;
            logic       prev;
`ifdef I2C_TGT_GLITCH_FILTER_EN
            logic [1:0] hist;
            logic       filt;
            // Line follows the synced input only once three samples agree
            assign line[gi] = (sync[1] == hist[0] && hist[0] == hist[1]) ? sync[1] : filt;

            // Sample history and held filter output; idle bus level is high
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    hist <= 2'b11;
                    filt <= 1'b1;
                end else begin
                    hist <= {hist[0], sync[1]};
                    filt <= line[gi];
                end
            end
`else
            assign line[gi] = sync[1];
`endif
            // Two-flop synchroniser plus previous-value flop for edge detection
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    sync <= 2'b11;
                    prev <= 1'b1;
                end else begin
                    sync <= {sync[0], pin[gi]};
                    prev <= line[gi];
                end
            end
            assign line_prev[gi] = prev;
        end
    endgenerate

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  =  line[1] & ~line_prev[1];
    assign scl_fall  = ~line[1] &  line_prev[1];
    assign start_det =  line[1] &  line_prev[1] &  line_prev[0] & ~line[0];
    assign stop_det  =  line[1] &  line_prev[1] & ~line_prev[0] &  line[0];

    state_t     state;
    logic [2:0] bit_cnt;
    logic [6:0] shift;
    logic [6:0] reg_addr;
    logic       d8;
    logic       ack_phase;
    logic [7:0] rx_byte;
    logic [8:0] regs [NUM_REGS];

    // The byte as it stands including the bit arriving on this SCL rise
    assign rx_byte = {shift, line[0]};

    // Readback is combinational; a same-cycle commit shows up one cycle later
    assign bus.rd_data = (bus.rd_addr < REG_LIMIT) ? regs[bus.rd_addr[IDX_W-1:0]] : 9'h000;

    // Frame decoder FSM with registered outputs and register-file writes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            bit_cnt       <= 3'd0;
            shift         <= 7'd0;
            reg_addr      <= 7'd0;
            d8            <= 1'b0;
            ack_phase     <= 1'b0;
            bus.sda_oe    <= 1'b0;
            bus.wr_valid  <= 1'b0;
            bus.wr_addr   <= 7'd0;
            bus.wr_data   <= 9'd0;
            bus.busy      <= 1'b0;
            bus.frame_cnt <= 8'd0;
            bus.err       <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 9'h000;
        end else begin
            bus.wr_valid <= 1'b0;
            if (start_det || stop_det) begin
                // A frame cut short after the address byte is an error
                if (state inside {ACK_A, REGHI, ACK_H, DATLO}) bus.err <= 1'b1;
                bus.sda_oe <= 1'b0;
                ack_phase  <= 1'b0;
                bit_cnt    <= 3'd0;
                state      <= start_det ? ADDR : IDLE;
                bus.busy   <= start_det;
            end else begin
                case (state)
                    IDLE: ;
                    ADDR, REGHI, DATLO, IGNORE: begin
                        if (scl_rise) begin
                            shift   <= rx_byte[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (state == ADDR) begin
                                    if (rx_byte[7:1] == DEV_ADDR && !rx_byte[0]) begin
                                        state <= ACK_A;
                                    end else begin
                                        state <= IGNORE;
                                        if (rx_byte[7:1] == DEV_ADDR) bus.err <= 1'b1;
                                    end
                                end else if (state == REGHI) begin
                                    reg_addr <= rx_byte[7:1];
                                    d8       <= rx_byte[0];
                                    if (rx_byte[7:1] >= REG_LIMIT && rx_byte[7:1] != RESET_REG) begin
                                        state   <= IGNORE;
                                        bus.err <= 1'b1;
                                    end else begin
                                        state <= ACK_H;
                                    end
                                end else if (state == DATLO) begin
                                    bus.wr_valid  <= 1'b1;
                                    bus.wr_addr   <= reg_addr;
                                    bus.wr_data   <= {d8, rx_byte};
                                    bus.frame_cnt <= bus.frame_cnt + 8'd1;
                                    if (reg_addr == RESET_REG) begin
                                        for (int i = 0; i < NUM_REGS; i++) regs[i] <= 9'h000;
                                    end else begin
                                        regs[reg_addr[IDX_W-1:0]] <= {d8, rx_byte};
                                    end
                                    state <= ACK_L;
                                end
                            end
                        end
                    end
                    ACK_A, ACK_H, ACK_L: begin
                        // Drive from the 8th falling edge to the 9th falling edge
                        if (scl_fall) begin
                            if (!ack_phase) begin
                                bus.sda_oe <= 1'b1;
                                ack_phase  <= 1'b1;
                            end else begin
                                bus.sda_oe <= 1'b0;
                                ack_phase  <= 1'b0;
                                bit_cnt    <= 3'd0;
                                state      <= (state == ACK_A) ? REGHI :
                                              (state == ACK_H) ? DATLO : IGNORE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_codec_target.sv
// Self-checking bench for i2c_codec_target: directed frames from the test
// plan, randomized frames against a frame-level reference model, reset
// mid-frame and line-glitch handling (I2C_TGT_GLITCH_FILTER_EN aware).
module tb_i2c_codec_target;
    localparam int Q = 8;  // clk cycles per quarter SCL period

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic sda_m = 1'b1;

    always #10 clk = ~clk;

    i2c_codec_target_if bus();
    // Open-drain SDA: master and target both pull low
    assign bus.sda_in = sda_m & ~bus.sda_oe;

    i2c_codec_target dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [8:0]  m_regs [19];
    logic [7:0]  m_cnt;
    logic        m_err;
    logic [15:0] m_wq[$];
    logic        exp_ack [8];
    logic [7:0]  tx [8];

    // Observed committed writes and busy activity
    logic [15:0] wq[$];
    bit          busy_seen;

    always @(negedge clk) begin
        if (reset_n && bus.wr_valid) wq.push_back({bus.wr_addr, bus.wr_data});
        if (bus.busy) busy_seen = 1'b1;
    end

    initial begin
        #(90000 * 20);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expected outcome of a frame of n bytes, terminated by STOP or START
    function automatic void model_frame(input int n);
        logic [6:0] ra;
        for (int i = 0; i < 8; i++) exp_ack[i] = 1'b0;
        if (tx[0][7:1] != 7'h1A) return;
        if (tx[0][0]) begin m_err = 1'b1; return; end
        exp_ack[0] = 1'b1;
        if (n < 2) begin m_err = 1'b1; return; end
        ra = tx[1][7:1];
        if (ra >= 7'd19 && ra != 7'h0F) begin m_err = 1'b1; return; end
        exp_ack[1] = 1'b1;
        if (n < 3) begin m_err = 1'b1; return; end
        exp_ack[2] = 1'b1;
        m_cnt = m_cnt + 8'd1;
        m_wq.push_back({ra, tx[1][0], tx[2]});
        if (ra == 7'h0F) begin
            for (int i = 0; i < 19; i++) m_regs[i] = 9'h000;
        end else begin
            m_regs[ra[4:0]] = {tx[1][0], tx[2]};
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 19; i++) m_regs[i] = 9'h000;
        m_cnt = 8'd0;
        m_err = 1'b0;
        m_wq.delete();
    endfunction

    task automatic i2c_start();
        wait_clk(Q); sda_m = 1'b1;
        wait_clk(Q); bus.scl = 1'b1;
        wait_clk(2*Q); sda_m = 1'b0;
        wait_clk(2*Q); bus.scl = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_clk(Q); sda_m = 1'b0;
        wait_clk(Q); bus.scl = 1'b1;
        wait_clk(2*Q); sda_m = 1'b1;
        wait_clk(2*Q);
    endtask

    task automatic send_bits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            wait_clk(Q); sda_m = b[i];
            wait_clk(Q); bus.scl = 1'b1;
            wait_clk(2*Q); bus.scl = 1'b0;
        end
    endtask

    // 9th clock: ACK counts only if sda_oe is held across the whole high phase
    task automatic ack_clock(output logic ack);
        logic a1;
        wait_clk(Q); sda_m = 1'b1;
        wait_clk(Q); bus.scl = 1'b1;
        wait_clk(1); a1 = bus.sda_oe;
        wait_clk(2*Q-1); ack = a1 & bus.sda_oe;
        bus.scl = 1'b0;
    endtask

    task automatic send_frame(input string tag, input int n, input bit do_stop);
        logic ack;
        model_frame(n);
        i2c_start();
        for (int i = 0; i < n; i++) begin
            send_bits(tx[i]);
            ack_clock(ack);
            check($sformatf("%s ack%0d", tag, i), {31'd0, ack}, {31'd0, exp_ack[i]});
        end
        if (do_stop) i2c_stop();
        wait_clk(8);
        $display("frame %s: n=%0d bytes=%h %h %h %h stop=%0d", tag, n, tx[0], tx[1], tx[2], tx[3], do_stop);
    endtask

    task automatic check_writes(input string tag);
        check({tag, " wr_count"}, wq.size(), m_wq.size());
        for (int i = 0; i < m_wq.size() && i < wq.size(); i++)
            check($sformatf("%s wr%0d", tag, i), {16'd0, wq[i]}, {16'd0, m_wq[i]});
        wq.delete();
        m_wq.delete();
    endtask

    task automatic check_state(input string tag);
        logic [6:0] a;
        logic [8:0] e;
        for (int i = 0; i < 22; i++) begin
            a = (i == 21) ? 7'd127 : 7'(i);
            bus.rd_addr = a;
            #1;
            e = (a < 7'd19) ? m_regs[a[4:0]] : 9'h000;
            check($sformatf("%s rd[%0h]", tag, a), {23'd0, bus.rd_data}, {23'd0, e});
        end
        check({tag, " frame_cnt"}, {24'd0, bus.frame_cnt}, {24'd0, m_cnt});
        check({tag, " err"}, {31'd0, bus.err}, {31'd0, m_err});
        check({tag, " busy"}, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        int n;
        logic [6:0] ra;
        bus.scl = 1'b1;
        bus.rd_addr = 7'd0;
        model_reset();
        for (int i = 0; i < 8; i++) tx[i] = 8'h00;

        // Reset state
        wait_clk(5);
        check("rst sda_oe", {31'd0, bus.sda_oe}, 32'd0);
        check("rst wr_valid", {31'd0, bus.wr_valid}, 32'd0);
        check("rst wr_addr", {25'd0, bus.wr_addr}, 32'd0);
        check("rst wr_data", {23'd0, bus.wr_data}, 32'd0);
        reset_n = 1'b1;
        wait_clk(5);
        check_state("reset");

        // Basic write: reg 6 <= 0x010
        tx[0] = 8'h34; tx[1] = 8'h0C; tx[2] = 8'h10;
        send_frame("t1", 3, 1'b1);
        check_writes("t1");
        check_state("t1");

        // Wrong device address, then matched address with read bit
        tx[0] = 8'h36;
        send_frame("t2a", 3, 1'b1);
        check_writes("t2a");
        check_state("t2a");
        tx[0] = 8'h35;
        send_frame("t2b", 3, 1'b1);
        check_writes("t2b");
        check_state("t2b");

        // d8 set, then a write to the register-file reset address
        tx[0] = 8'h34; tx[1] = 8'h01; tx[2] = 8'h79;
        send_frame("t3a", 3, 1'b1);
        check_writes("t3a");
        check_state("t3a");
        tx[1] = 8'h1E; tx[2] = 8'h00;
        send_frame("t3b", 3, 1'b1);
        check_writes("t3b");
        check_state("t3b");

        // Repeated START after the register byte discards the partial frame
        tx[1] = 8'h0C; tx[2] = 8'h55;
        send_frame("t4a", 2, 1'b0);
        tx[1] = 8'h12; tx[2] = 8'h01;
        send_frame("t4b", 3, 1'b1);
        check_writes("t4");
        check_state("t4");

        // Extra 4th byte is NACKed
        tx[3] = 8'hAA;
        send_frame("t5", 4, 1'b1);
        check_writes("t5");
        check_state("t5");

        // Randomized frames
        for (int k = 0; k < 14; k++) begin
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 3;
            tx[0] = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h34;
            ra = 7'($urandom_range(0, 20));
            tx[1] = {ra, 1'($urandom)};
            tx[2] = 8'($urandom);
            tx[3] = 8'($urandom);
            send_frame($sformatf("rnd%0d", k), n, 1'b1);
            check_writes($sformatf("rnd%0d", k));
            check_state($sformatf("rnd%0d", k));
        end

        // Short SDA spikes while SCL is high and the bus is idle
        busy_seen = 1'b0;
`ifdef I2C_TGT_GLITCH_FILTER_EN
        @(negedge clk) sda_m = 1'b0;
        repeat (2) @(negedge clk);
        sda_m = 1'b1;
        wait_clk(12);
        check("glitch2 ignored", {31'd0, busy_seen}, 32'd0);
        $display("glitch: 2-clk SDA pulse");
        busy_seen = 1'b0;
        @(negedge clk) sda_m = 1'b0;
        repeat (4) @(negedge clk);
        sda_m = 1'b1;
        wait_clk(12);
        check("glitch4 start", {31'd0, busy_seen}, 32'd1);
        $display("glitch: 4-clk SDA pulse");
`else
        @(negedge clk) sda_m = 1'b0;
        @(negedge clk) sda_m = 1'b1;
        wait_clk(12);
        check("glitch1 start", {31'd0, busy_seen}, 32'd1);
        $display("glitch: 1-clk SDA pulse");
`endif
        check_state("glitch");

        // Reset in the middle of an ACK slot
        tx[0] = 8'h34;
        i2c_start();
        send_bits(tx[0]);
        wait_clk(Q); sda_m = 1'b1;
        wait_clk(Q); bus.scl = 1'b1;
        wait_clk(2);
        check("pre-rst sda_oe", {31'd0, bus.sda_oe}, 32'd1);
        check("pre-rst busy", {31'd0, bus.busy}, 32'd1);
        #3 reset_n = 1'b0;
        #1;
        check("async sda_oe", {31'd0, bus.sda_oe}, 32'd0);
        check("async busy", {31'd0, bus.busy}, 32'd0);
        check("async frame_cnt", {24'd0, bus.frame_cnt}, 32'd0);
        $display("reset asserted mid-frame");
        model_reset();
        wq.delete();
        wait_clk(4);
        reset_n = 1'b1;
        wait_clk(5);
        check_state("post-rst");

        // Normal operation after reset
        tx[0] = 8'h34; tx[1] = 8'h0C; tx[2] = 8'h10;
        send_frame("t6", 3, 1'b1);
        check_writes("t6");
        check_state("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
